// File: rtl/signed_divider_pkg.sv
// Shared types and constants for the signed restoring divider.
package divider_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int STATE_W       = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

endpackage

// File: rtl/signed_divider_if.sv
// Operand/result bundle for signed_divider: the master drives operands, the slave returns results.
interface signed_divider_if
  import divider_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
);

  logic         en;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         out_valid;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic         ovf;

  modport master (
    output en, in_valid, A, B,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, ovf
  );

  modport slave (
    input  en, in_valid, A, B,
    output in_ready, out_valid, quotient, remainder, div_by_zero, ovf
  );

endinterface

// File: rtl/signed_divider_div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step #(
  parameter int N = 8
) (
  input  logic [N:0] partial,
  input  logic       next_bit,
  input  logic [N:0] divisor,
  output logic [N:0] partial_next,
  output logic       quot_bit
);

  logic [N+1:0] shifted;
  logic [N+1:0] diff;

  // The extra top bit of diff acts as the borrow of the trial subtraction.
  assign shifted      = {partial, next_bit};
  assign diff         = shifted - {1'b0, divisor};
  assign quot_bit     = ~diff[N+1];
  assign partial_next = quot_bit ? diff[N:0] : shifted[N:0];

endmodule

// File: rtl/signed_divider.sv
// Sequential signed divider, one quotient bit per cycle.
// Optional feature: define SIGNED_DIVIDER_OVF_SAT_EN to saturate most-negative / -1 and flag ovf.
module signed_divider
  import divider_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input logic             CLK,
  input logic             RST,
  signed_divider_if.slave bus
);

  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   count;
  logic [N-1:0]       dividend;
  logic [N:0]         divisor;
  logic [N:0]         partial;
  logic               sign_q;
  logic               sign_r;
  logic               dbz;

  logic [N-1:0]       a_abs;
  logic [N:0]         b_abs;
  logic [N:0]         step_partial;
  logic               step_bit;
  logic [N-1:0]       rem_mag;
  logic [N-1:0]       q_signed;
  logic [N-1:0]       r_signed;

  div_step #(.N(N)) u_step (
    .partial      (partial),
    .next_bit     (dividend[N-1]),
    .divisor      (divisor),
    .partial_next (step_partial),
    .quot_bit     (step_bit)
  );

  assign a_abs         = bus.A[N-1] ? -bus.A : bus.A;
  assign b_abs         = {1'b0, (bus.B[N-1] ? -bus.B : bus.B)};
  assign bus.in_ready  = (state == IDLE);

  // The dividend register shifts out dividend bits and shifts in quotient bits,
  // so after the last iteration it holds |quotient|; on divide-by-zero it still holds |A|.
  assign rem_mag  = dbz ? dividend : partial[N-1:0];
  assign q_signed = sign_q ? -dividend : dividend;
  assign r_signed = sign_r ? -rem_mag : rem_mag;

`ifdef SIGNED_DIVIDER_OVF_SAT_EN
  logic sat_case;
  // A positive quotient magnitude of 2^(N-1) only arises from most-negative / -1.
  assign sat_case = ~dbz & ~sign_q & dividend[N-1];
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
    end else if (bus.en) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.in_valid) state_next = (bus.B == '0) ? SIGN : CALC;
      CALC: if (count == '0) state_next = SIGN;
      SIGN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      count           <= '0;
      dividend        <= '0;
      divisor         <= '0;
      partial         <= '0;
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
      dbz             <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.ovf         <= 1'b0;
    end else if (bus.en) begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dividend <= a_abs;
            divisor  <= b_abs;
            partial  <= '0;
            sign_q   <= bus.A[N-1] ^ bus.B[N-1];
            sign_r   <= bus.A[N-1];
            dbz      <= (bus.B == '0);
            count    <= CNT_W'(N - 1);
          end
        end
        CALC: begin
          partial  <= step_partial;
          dividend <= {dividend[N-2:0], step_bit};
          count    <= count - CNT_W'(1);
        end
        SIGN: begin
          bus.out_valid   <= 1'b1;
          bus.div_by_zero <= dbz;
          bus.remainder   <= r_signed;
          if (dbz) begin
            bus.quotient <= '1;
          end else begin
            bus.quotient <= q_signed;
          end
`ifdef SIGNED_DIVIDER_OVF_SAT_EN
          bus.ovf <= sat_case;
          if (sat_case) begin
            bus.quotient <= {1'b0, {(N-1){1'b1}}};
          end
`else
          bus.ovf <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider: directed cases, stall/busy/reset scenarios, random operands.
module tb_signed_divider;

  localparam int N = 8;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  signed_divider_if #(.N(N)) bus ();

  signed_divider #(.N(N)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour from plain integer arithmetic (truncating division, remainder follows dividend).
  function automatic void refModel(input logic [N-1:0] a, input logic [N-1:0] b,
                                   output logic [N-1:0] q, output logic [N-1:0] r,
                                   output logic dz, output logic ov);
    int sa, sb, iq, ir;
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0;
    ov = 1'b0;
    if (sb == 0) begin
      iq = -1;
      ir = sa;
      dz = 1'b1;
    end else if (sa == -(1 << (N - 1)) && sb == -1) begin
`ifdef SIGNED_DIVIDER_OVF_SAT_EN
      iq = (1 << (N - 1)) - 1;
      ov = 1'b1;
`else
      iq = -(1 << (N - 1));
`endif
      ir = 0;
    end else begin
      iq = sa / sb;
      ir = sa % sb;
    end
    q = iq[N-1:0];
    r = ir[N-1:0];
  endfunction

  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               input int stallAt, input int stallLen,
                               input bit pokeBusy, input string tag);
    logic [N-1:0] eq, er;
    logic         ed, eo;
    int           lat;
    int           expLat;
    refModel(a, b, eq, er, ed, eo);
    expLat = ((b == '0) ? 1 : N + 1) + stallLen;
    @(negedge clk);
    checkOutput({tag, "/ready"}, 32'(bus.in_ready), 32'd1);
    bus.en       = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = pokeBusy;
    bus.A        = N'($urandom);
    bus.B        = N'($urandom_range(1, 255));
    if (pokeBusy) checkOutput({tag, "/busy_ready"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (lat < 60) begin
      bus.en = !(stallLen > 0 && lat >= stallAt && lat < stallAt + stallLen);
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.out_valid) break;
    end
    bus.in_valid = 1'b0;
    bus.en       = 1'b1;
    checkOutput({tag, "/latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "/quotient"}, 32'(bus.quotient), 32'(eq));
    checkOutput({tag, "/remainder"}, 32'(bus.remainder), 32'(er));
    checkOutput({tag, "/dbz"}, 32'(bus.div_by_zero), 32'(ed));
    checkOutput({tag, "/ovf"}, 32'(bus.ovf), 32'(eo));
    checkOutput({tag, "/ready_at_valid"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    checkOutput({tag, "/strobe_low"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "/quot_hold"}, 32'(bus.quotient), 32'(eq));
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    compared     = 0;
    mismatched   = 0;
    rst          = 1'b0;
    bus.en       = 1'b1;
    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset/out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset/in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset/quotient", 32'(bus.quotient), 32'd0);
    checkOutput("reset/remainder", 32'(bus.remainder), 32'd0);
    checkOutput("reset/flags", 32'({bus.div_by_zero, bus.ovf}), 32'd0);
    rst = 1'b1;

    applyStimulus(8'd100, 8'd7, 0, 0, 1'b0, "p100_7");
    applyStimulus(8'h9C, 8'd7, 0, 0, 1'b0, "n100_7");
    applyStimulus(8'h9C, 8'hF9, 0, 0, 1'b0, "n100_n7");
    applyStimulus(8'd5, 8'd0, 0, 0, 1'b0, "div0_pos");
    applyStimulus(8'h80, 8'd0, 0, 0, 1'b0, "div0_min");
    applyStimulus(8'h80, 8'hFF, 0, 0, 1'b0, "min_by_m1");
    applyStimulus(8'h80, 8'd1, 0, 0, 1'b0, "min_by_1");
    applyStimulus(8'd127, 8'd3, 3, 4, 1'b1, "stall_busy");

    // Abort an operation mid-iteration with reset.
    @(negedge clk);
    bus.A        = 8'd100;
    bus.B        = 8'd7;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("abort/out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort/in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("abort/quotient", 32'(bus.quotient), 32'd0);
    checkOutput("abort/remainder", 32'(bus.remainder), 32'd0);
    checkOutput("abort/flags", 32'({bus.div_by_zero, bus.ovf}), 32'd0);
    applyStimulus(8'd20, 8'd6, 0, 0, 1'b0, "after_reset");

    for (int i = 0; i < 24; i++) begin
      ra = N'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      applyStimulus(ra, rb, 0, 0, 1'b0, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/signed_divider.md
# signed_divider

Sequential signed two's-complement integer divider: one N-bit dividend by one N-bit divisor, producing an N-bit quotient and N-bit remainder. It is the inverse-arithmetic companion to the team's signed multiplier and feeds the communication datapath wherever scaling or normalization by a runtime value is needed. It uses a restoring shift-subtract algorithm, one quotient bit per cycle, with a valid/ready input handshake and a one-cycle output strobe.

## Interface
- N, 8, operand and result width in bits (N ≥ 2)
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous active-low reset
- en  in  1  clock enable; low freezes all state and outputs
- in_valid  in  1  A/B valid
- in_ready  out  1  divider can accept operands (high only in IDLE)
- A  in  N  signed dividend
- B  in  N  signed divisor
- out_valid  out  1  one-cycle strobe: results valid
- quotient  out  N  signed quotient, truncated toward zero
- remainder  out  N  signed remainder, sign follows dividend
- div_by_zero  out  1  result came from B == 0
- ovf  out  1  result came from most-negative / -1

## Operation
- Reset (RST low at a rising edge): state IDLE, in_ready 1, out_valid 0, quotient 0, remainder 0, div_by_zero 0, ovf 0, internal registers 0.
- Acceptance: rising edge with en & in_valid & in_ready. Capture |A|, |B|, sign_q = A[N-1]^B[N-1], sign_r = A[N-1]; clear partial remainder.
- States:
  - IDLE: in_ready = 1. On acceptance: B == 0 → SIGN with dbz flag set; otherwise → CALC with iteration counter = N-1.
  - CALC: shift partial remainder left by one, bringing in the next dividend MSB; trial-subtract |B|; if non-negative, keep the difference and set the quotient bit to 1, else restore and set it to 0. The counter decrements; on count 0 → SIGN.
  - SIGN: apply sign_q to the quotient magnitude and sign_r to the remainder magnitude. Register the outputs, pulse out_valid, go to IDLE.
- Arithmetic: magnitudes are held in N+1 bits, so |−2^(N−1)| is representable. The subtractor is N+1 bits wide. Final negation is two's complement truncated to N bits.
- Divide by zero: quotient = all ones, remainder = A, div_by_zero = 1, ovf = 0.
- Overflow case (A = −2^(N−1), B = −1): behaviour is set by the Configuration macro.
- Output registers (quotient, remainder, flags) hold their values until the next SIGN state or a reset. out_valid is high for exactly one en-qualified cycle.
- in_valid while in_ready is low is ignored. Operands are not queued.
- en low in any state: no state, counter, or output change. An out_valid pulse in progress stays high until the next en-high edge.

## Timing
- Normal division latency is N+1 en-high edges after the acceptance edge: N CALC edges then 1 SIGN edge. For N=8, out_valid is high in the cycle after the 9th en-high edge following acceptance.
- Divide by zero: out_valid is high after the 1st en-high edge following acceptance.
- in_ready rises in the same cycle that out_valid is high. A new operand pair may be accepted on that edge, giving back-to-back throughput of one result every N+2 edges.
- Reset in the middle of an operation aborts the operation on that edge. No out_valid is produced for it.
- No combinational path from inputs to outputs.

## Configuration
- SIGNED_DIVIDER_OVF_SAT_EN
  - Defined: A = −2^(N−1), B = −1 produces quotient = 2^(N−1)−1 (0x7F for N=8), remainder = 0, ovf = 1.
  - Undefined: the quotient wraps to −2^(N−1) (0x80), remainder = 0, and ovf is tied to 0.
  - Latency is identical in both builds.

## Structure
- Package divider_pkg: state enum (IDLE, CALC, SIGN), state width constant, and the default width constant.
- One sub-module, div_step: combinational single restoring iteration. Inputs are the partial remainder, the next dividend bit, and |B|. Outputs are the new partial remainder and the quotient bit. The top module holds the FSM, counter, sign handling, and output registers.

## Test plan
- A=100, B=7, en=1 → after 9 edges: quotient 14 (0x0E), remainder 2, out_valid one cycle, flags 0.
- A=−100 (0x9C), B=7 → quotient −14 (0xF2), remainder −2 (0xFE). A=−100, B=−7 → quotient 14, remainder −2.
- A=5, B=0 → after 1 edge: quotient 0xFF, remainder 5, div_by_zero 1.
- A=0x80, B=0xFF:
  - macro defined → quotient 0x7F, remainder 0, ovf 1.
  - macro undefined → quotient 0x80, ovf 0.
  - A=0x80, B=1 → quotient 0x80, remainder 0.
- Stall and overlap: start 127/3, hold en low for 4 cycles mid-CALC → result (42, 1) arrives 4 cycles late. Assert in_valid while busy → no capture, in_ready 0.
- Reset: RST low during CALC → next cycle all outputs 0 and in_ready 1. A new 20/6 then yields (3, 2) with normal latency.
